mem_copy_sequencer: RTL and testbench

Controller that sequences a word-by-word memory-to-memory block copy over a single-port synchronous memory. It owns the 16-bit address, data and count registers of the move datapath and drives their loads and the memory port. It sits between the instruction decode/control unit, which issues `start` with operands, and the main data memory.

---
 rtl/mem_copy_sequencer_pkg.sv | 13 +
 rtl/mem_copy_sequencer_if.sv | 28 ++
 rtl/mem_copy_sequencer_reg.sv | 19 +
 rtl/mem_copy_sequencer.sv | 100 ++++++++++
 tb/tb_mem_copy_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mem_copy_sequencer_pkg.sv
// Shared types for the memory-move datapath: FSM state encoding and default widths.
package mem_move_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_t;
endpackage

// File: rtl/mem_copy_sequencer_if.sv
// Control-unit operands plus the single-port memory bus of the copy sequencer.
interface mem_copy_sequencer_if
   import mem_move_pkg::*;
();
   logic                  start;
   logic [ADDR_WIDTH-1:0] srcAddr;
   logic [ADDR_WIDTH-1:0] dstAddr;
   logic [ADDR_WIDTH-1:0] length;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic                  memWrite;
   logic [DATA_WIDTH-1:0] memWriteData;
   logic [DATA_WIDTH-1:0] memReadData;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] remaining;

   // master: the sequencer, which owns the memory port.
   modport master (
      input  start, srcAddr, dstAddr, length, memReadData,
      output memAddr, memWrite, memWriteData, busy, done, remaining
   );

   // slave: decode unit and memory side.
   modport slave (
      output start, srcAddr, dstAddr, length, memReadData,
      input  memAddr, memWrite, memWriteData, busy, done, remaining
   );
endinterface

// File: rtl/mem_copy_sequencer_reg.sv
// Loadable register with asynchronous clear; holds its value when load is low.
module register16_en
   import mem_move_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] inputValue,
   output logic [W-1:0] outputValue
);
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         outputValue <= '0;
      else if (load)
         outputValue <= inputValue;
   end
endmodule

// File: rtl/mem_copy_sequencer.sv
// Word-by-word block copy: READ, CAPTURE, WRITE per word (3 cycles/word), then a one-cycle DONE.
// start is only honoured in IDLE; reset aborts immediately with no further write.
module mem_copy_sequencer
   import mem_move_pkg::*;
(
   input logic                  CLK,
   input logic                  reset,
   mem_copy_sequencer_if.master bus
);
   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] src_q, dst_q, cnt_q;
   logic [ADDR_WIDTH-1:0] src_d, dst_d, cnt_d, cnt_dec;
   logic [DATA_WIDTH-1:0] mdr_q;
   logic                  addr_ld, mdr_ld;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_write, busy_o, done_o;

   assign cnt_dec = cnt_q - ADDR_WIDTH'(1);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = (bus.length != '0) ? READ : DONE;
         READ:    state_d = CAPTURE;
         CAPTURE: state_d = WRITE;
         WRITE:   state_d = (cnt_dec != '0) ? READ : DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // SRC/DST/CNT share one load: operand capture in IDLE, step in WRITE.
   always_comb begin
      mem_addr  = '0;
      mem_write = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      addr_ld   = 1'b0;
      mdr_ld    = 1'b0;
      src_d     = src_q + ADDR_WIDTH'(1);
      dst_d     = dst_q + ADDR_WIDTH'(1);
      cnt_d     = cnt_dec;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               addr_ld = 1'b1;
               src_d   = bus.srcAddr;
               dst_d   = bus.dstAddr;
               cnt_d   = bus.length;
            end
         end
         READ: begin
            mem_addr = src_q;
            busy_o   = 1'b1;
         end
         CAPTURE: begin
            mem_addr = src_q;
            busy_o   = 1'b1;
            mdr_ld   = 1'b1;
         end
         WRITE: begin
            mem_addr  = dst_q;
            mem_write = 1'b1;
            busy_o    = 1'b1;
            addr_ld   = 1'b1;
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   register16_en #(.W(ADDR_WIDTH)) u_src (
      .CLK(CLK), .reset(reset), .load(addr_ld), .inputValue(src_d), .outputValue(src_q)
   );
   register16_en #(.W(ADDR_WIDTH)) u_dst (
      .CLK(CLK), .reset(reset), .load(addr_ld), .inputValue(dst_d), .outputValue(dst_q)
   );
   register16_en #(.W(ADDR_WIDTH)) u_cnt (
      .CLK(CLK), .reset(reset), .load(addr_ld), .inputValue(cnt_d), .outputValue(cnt_q)
   );
   register16_en #(.W(DATA_WIDTH)) u_mdr (
      .CLK(CLK), .reset(reset), .load(mdr_ld), .inputValue(bus.memReadData), .outputValue(mdr_q)
   );

   assign bus.memAddr      = mem_addr;
   assign bus.memWrite     = mem_write;
   assign bus.memWriteData = mdr_q;
   assign bus.busy         = busy_o;
   assign bus.done         = done_o;
   assign bus.remaining    = cnt_q;
endmodule

// File: tb/tb_mem_copy_sequencer.sv
// Bench for mem_copy_sequencer: synchronous-read memory plus a forward-copy reference model.
module tb_mem_copy_sequencer;
   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   mem_copy_sequencer_if bus ();
   mem_copy_sequencer dut (.CLK(CLK), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   // Memory model: untouched words read as a fixed function of their address.
   logic [15:0] mem [0:65535];
   bit          written [0:65535];
   logic [15:0] rd_q;
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = '0, pre_dat = '0;
   logic [15:0] refmem [logic [15:0]];

   function automatic logic [15:0] init_fn(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      return written[a] ? mem[a] : init_fn(a);
   endfunction

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return refmem.exists(a) ? refmem[a] : init_fn(a);
   endfunction

   always @(posedge CLK) begin
      rd_q <= mem_rd(bus.memAddr);
      if (bus.memWrite) begin
         mem[bus.memAddr]     <= bus.memWriteData;
         written[bus.memAddr] <= 1'b1;
      end else if (pre_we) begin
         mem[pre_addr]     <= pre_dat;
         written[pre_addr] <= 1'b1;
      end
   end
   assign bus.memReadData = rd_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [15:0] d);
      pre_we = 1'b1; pre_addr = a; pre_dat = d;
      @(negedge CLK);
      pre_we = 1'b0;
      refmem[a] = d;
   endtask

   // Issues one copy and checks every cycle against the expected READ/CAPTURE/WRITE trace.
   task automatic run_copy(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                           input int glitch_a, input int glitch_b, input bit start_in_done,
                           input int abort_cyc);
      bit aborted = 0;
      logic [15:0] sa, da, exp_d;
      int i, ph;
      bus.start = 1'b1; bus.srcAddr = src; bus.dstAddr = dst; bus.length = len;
      @(negedge CLK);
      bus.start = 1'b0;
      bus.srcAddr = 16'($urandom); bus.dstAddr = 16'($urandom); bus.length = 16'($urandom);
      for (int c = 0; c < 3 * int'(len); c++) begin
         i = c / 3; ph = c % 3;
         sa = src + 16'(i); da = dst + 16'(i);
         if (c == abort_cyc) begin
            reset = 1'b1;
            #1;
            check("abort_memWrite", bus.memWrite, 0);
            check("abort_memAddr", bus.memAddr, 0);
            check("abort_busy", bus.busy, 0);
            check("abort_remaining", bus.remaining, 0);
            check("abort_wdata", bus.memWriteData, 0);
            @(negedge CLK);
            reset = 1'b0;
            @(negedge CLK);
            check("post_abort_busy", bus.busy, 0);
            check("post_abort_done", bus.done, 0);
            aborted = 1;
            break;
         end
         check("memAddr", bus.memAddr, (ph == 2) ? da : sa);
         check("memWrite", bus.memWrite, (ph == 2) ? 1 : 0);
         check("busy", bus.busy, 1);
         check("done_busy", bus.done, 0);
         check("remaining", bus.remaining, len - 16'(i));
         if (ph == 2) begin
            exp_d = ref_rd(sa);
            check("memWriteData", bus.memWriteData, exp_d);
            refmem[da] = exp_d;
         end
         if (c == glitch_a || c == glitch_b) begin
            bus.start = 1'b1;
            bus.srcAddr = 16'($urandom); bus.dstAddr = 16'($urandom); bus.length = 16'd1;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge CLK);
      end
      if (!aborted) begin
         check("done", bus.done, 1);
         check("done_state_busy", bus.busy, 0);
         check("done_memAddr", bus.memAddr, 0);
         check("done_memWrite", bus.memWrite, 0);
         check("done_remaining", bus.remaining, 0);
         bus.start = start_in_done;
         @(negedge CLK);
         bus.start = 1'b0;
         check("idle_done", bus.done, 0);
         check("idle_busy", bus.busy, 0);
      end
      for (int k = 0; k < int'(len); k++)
         check("mem_region", mem_rd(dst + 16'(k)), ref_rd(dst + 16'(k)));
   endtask

   initial begin
      logic [15:0] rs, rd, rl;
      reset = 1'b1;
      bus.start = 1'b0; bus.srcAddr = '0; bus.dstAddr = '0; bus.length = '0;
      @(negedge CLK);
      @(negedge CLK);
      check("rst_memAddr", bus.memAddr, 0);
      check("rst_memWrite", bus.memWrite, 0);
      check("rst_wdata", bus.memWriteData, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_remaining", bus.remaining, 0);
      reset = 1'b0;
      @(negedge CLK);

      poke(16'h0010, 16'hBEEF);
      run_copy(16'h0010, 16'h0020, 16'd1, -1, -1, 0, -1);
      check("single_word", mem_rd(16'h0020), 16'hBEEF);

      for (int k = 0; k < 4; k++) poke(16'h0100 + 16'(k), 16'(k + 1));
      run_copy(16'h0100, 16'h0200, 16'd4, -1, -1, 0, -1);
      for (int k = 0; k < 4; k++) check("four_word", mem_rd(16'h0200 + 16'(k)), 32'(k + 1));

      run_copy(16'h0300, 16'h0400, 16'd0, -1, -1, 0, -1);

      run_copy(16'hFFFE, 16'h7FFF, 16'd3, -1, -1, 0, -1);

      // Start pulses in READ and WRITE of word 1 and in DONE must all be ignored.
      run_copy(16'h1000, 16'h2000, 16'd4, 3, 5, 1, -1);

      run_copy(16'h3000, 16'h4000, 16'd4, -1, -1, 0, 8);
      check("abort_word2_unwritten", mem_rd(16'h4002), init_fn(16'h4002));

      for (int n = 0; n < 6; n++) begin
         rs = 16'($urandom);
         rd = (n % 2 == 0) ? rs + 16'd1 : 16'($urandom);
         rl = 16'($urandom_range(1, 5));
         run_copy(rs, rd, rl, -1, -1, 0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
